// File: rtl/endec_pkg.sv
// Shared endec types: code-rate enum, frame geometry and frame_t.
// Used by symbol_frame_packer and its frame buffers.
package endec_pkg;

    typedef enum logic {
        CODE_RATE_2 = 1'b0,
        CODE_RATE_3 = 1'b1
    } code_rate_e;

    localparam int MAX_CODE_RATE  = 3;
    localparam int SYMS_PER_FRAME = 128;
    localparam int FRAME_W        = SYMS_PER_FRAME * MAX_CODE_RATE;
    localparam int CNT_W          = $clog2(SYMS_PER_FRAME);
    localparam int LEN_W          = CNT_W + 1;
    localparam int IDX_W          = $clog2(FRAME_W);

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/symbol_frame_packer_if.sv
// Symbol intake and frame output handshake bundle of the packer.
// slave = packer side, master = source/decoder side.
interface symbol_frame_packer_if;
    import endec_pkg::*;

    logic                     i_code_rate;
    logic                     i_sym_valid;
    logic [MAX_CODE_RATE-1:0] i_sym_data;
    logic                     o_sym_ready;
    logic                     i_flush;
    logic                     o_frame_valid;
    frame_t                   o_frame_data;
    logic                     o_frame_rate;
    logic [LEN_W-1:0]         o_frame_len;
    logic                     i_frame_ready;

    modport slave (
        input  i_code_rate, i_sym_valid, i_sym_data, i_flush, i_frame_ready,
        output o_sym_ready, o_frame_valid, o_frame_data, o_frame_rate, o_frame_len
    );

    modport master (
        output i_code_rate, i_sym_valid, i_sym_data, i_flush, i_frame_ready,
        input  o_sym_ready, o_frame_valid, o_frame_data, o_frame_rate, o_frame_len
    );

endinterface

// File: rtl/sfp_frame_buf.sv
// One half of the ping-pong buffer: frame, rate and length registers.
// Symbol k lands MSB-first at field (SYMS-1-k) of width rate.
module sfp_frame_buf
    import endec_pkg::*;
(
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic                     i_first,
    input  logic                     i_close,
    input  logic                     i_rate,
    input  logic [MAX_CODE_RATE-1:0] i_sym,
    input  logic [CNT_W-1:0]         i_idx,
    input  logic [LEN_W-1:0]         i_len,
    output frame_t                   o_data,
    output logic                     o_rate,
    output logic [LEN_W-1:0]         o_len
);

    frame_t           r_data;
    logic             r_rate;
    logic [LEN_W-1:0] r_len;

    logic             w_rate;
    logic             w_is_r3;
    logic [CNT_W-1:0] w_rev;
    logic [IDX_W-1:0] w_rev_x;
    logic [IDX_W-1:0] w_base;

    // The first symbol is placed with the rate being latched alongside it.
    assign w_rate  = i_first ? i_rate : r_rate;
    assign w_is_r3 = (w_rate == CODE_RATE_3);
    assign w_rev   = CNT_W'(SYMS_PER_FRAME - 1) - i_idx;
    assign w_rev_x = IDX_W'(w_rev);
    assign w_base  = w_is_r3 ? (w_rev_x + w_rev_x + w_rev_x)
                             : (w_rev_x + w_rev_x);

    // Field write, rate latch, length on close; clear returns to all-zero.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_rate <= 1'b0;
            r_len  <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_rate <= 1'b0;
            r_len  <= '0;
        end else begin
            if (i_wr) begin
                if (i_first)
                    r_rate <= i_rate;
                if (w_is_r3)
                    r_data[w_base +: 3] <= i_sym;
                else
                    r_data[w_base +: 2] <= i_sym[1:0];
            end
            if (i_close)
                r_len <= i_len;
        end
    end

    assign o_data = r_data;
    assign o_rate = r_rate;
    assign o_len  = r_len;

endmodule

// File: rtl/symbol_frame_packer.sv
// Packs code symbols into SYMS-symbol frames for the Viterbi decoder.
// Optional partial-frame flush is enabled by defining SFP_FLUSH_EN.
module symbol_frame_packer
    import endec_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 rst,
    symbol_frame_packer_if.slave io_bus
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_full;

    logic             w_sym_ready;
    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic             w_flush;
    logic             w_close;
    logic             w_first;
    logic [LEN_W-1:0] w_len;
    frame_t           w_data [2];
    logic [1:0]       w_rate;
    logic [LEN_W-1:0] w_blen [2];

    assign w_sym_ready = ~r_full[r_wr_sel];
    assign w_accept    = io_bus.i_sym_valid & w_sym_ready;
    assign w_release   = r_full[r_rd_sel] & io_bus.i_frame_ready;
    assign w_last      = w_accept & (r_cnt == CNT_W'(SYMS_PER_FRAME - 1));
    assign w_first     = (r_cnt == '0);

`ifdef SFP_FLUSH_EN
    assign w_flush = io_bus.i_flush & ~w_first & ~w_last;
`else
    logic w_unused_flush;
    assign w_unused_flush = io_bus.i_flush;
    assign w_flush        = 1'b0;
`endif

    assign w_close = w_last | w_flush;
    assign w_len   = w_last ? LEN_W'(SYMS_PER_FRAME)
                            : LEN_W'(r_cnt) + LEN_W'(w_accept);

    for (genvar g = 0; g < 2; g++) begin : g_buf
        sfp_frame_buf u_buf (
            .sys_clk (sys_clk),
            .rst     (rst),
            .i_clr   (w_release & (r_rd_sel == 1'(g))),
            .i_wr    (w_accept & (r_wr_sel == 1'(g))),
            .i_first (w_first),
            .i_close (w_close & (r_wr_sel == 1'(g))),
            .i_rate  (io_bus.i_code_rate),
            .i_sym   (io_bus.i_sym_data),
            .i_idx   (r_cnt),
            .i_len   (w_len),
            .o_data  (w_data[g]),
            .o_rate  (w_rate[g]),
            .o_len   (w_blen[g])
        );
    end

    // Write pointer, read pointer and full flags; close and release
    // always target different buffers, so both can land in one cycle.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= 2'b00;
        end else begin
            if (w_close) begin
                r_full[r_wr_sel] <= 1'b1;
                r_cnt            <= '0;
                r_wr_sel         <= ~r_wr_sel;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
        end
    end

    assign io_bus.o_sym_ready   = w_sym_ready;
    assign io_bus.o_frame_valid = r_full[r_rd_sel];
    assign io_bus.o_frame_data  = w_data[r_rd_sel];
    assign io_bus.o_frame_rate  = w_rate[r_rd_sel];
    assign io_bus.o_frame_len   = w_blen[r_rd_sel];

endmodule

// File: tb/tb_symbol_frame_packer.sv
// Scoreboard bench for symbol_frame_packer.
// Define SFP_FLUSH_EN to also exercise the flush path.
module tb_symbol_frame_packer;
    import endec_pkg::*;

    typedef struct {
        frame_t           data;
        logic             rate;
        logic [LEN_W-1:0] len;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    exp_t   sb [$];
    exp_t   mon_e;
    frame_t m_f;
    int     m_cnt;
    logic   m_rate;

    symbol_frame_packer_if bus ();

    symbol_frame_packer dut (
        .sys_clk (sys_clk),
        .rst     (rst_n),
        .io_bus  (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void model_push();
        exp_t e;
        e.data = m_f;
        e.rate = m_rate;
        e.len  = LEN_W'(m_cnt);
        sb.push_back(e);
        m_f   = '0;
        m_cnt = 0;
    endfunction

    function automatic void model_accept(input logic [2:0] s, input logic r);
        if (m_cnt == 0)
            m_rate = r;
        if (m_rate)
            m_f[3*SYMS_PER_FRAME-1-3*m_cnt -: 3] = s;
        else
            m_f[2*SYMS_PER_FRAME-1-2*m_cnt -: 2] = s[1:0];
        m_cnt++;
        if (m_cnt == SYMS_PER_FRAME)
            model_push();
    endfunction

    // Consumer side: every frame handed to the decoder is checked in order.
    always begin
        @(negedge sys_clk);
        #2;
        if (rst_n && bus.o_frame_valid && bus.i_frame_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame got len=%0d", bus.o_frame_len);
            end else begin
                mon_e = sb.pop_front();
                if (bus.o_frame_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL frame_data got=%h exp=%h",
                             bus.o_frame_data, mon_e.data);
                end
                checks++;
                if (bus.o_frame_rate !== mon_e.rate) begin
                    failures++;
                    $display("FAIL frame_rate got=%b exp=%b",
                             bus.o_frame_rate, mon_e.rate);
                end
                checks++;
                if (bus.o_frame_len !== mon_e.len) begin
                    failures++;
                    $display("FAIL frame_len got=%0d exp=%0d",
                             bus.o_frame_len, mon_e.len);
                end
            end
        end
    end

    task automatic send_sym(input logic [2:0] s, input logic r);
        int n;
        n = 0;
        @(negedge sys_clk);
        bus.i_sym_valid = 1'b1;
        bus.i_sym_data  = s;
        bus.i_code_rate = r;
        while (!bus.o_sym_ready && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL sym_timeout ready=%b exp=1", bus.o_sym_ready);
            bus.i_sym_valid = 1'b0;
        end else begin
            @(posedge sys_clk);
            model_accept(s, r);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge sys_clk);
        bus.i_sym_valid = 1'b0;
        bus.i_flush     = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d exp=0", tag, sb.size());
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.o_sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_sym_ready got=%b exp=1", tag, bus.o_sym_ready);
        end
        checks++;
        if (bus.o_frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid got=%b exp=0", tag, bus.o_frame_valid);
        end
        checks++;
        if (bus.o_frame_data !== '0) begin
            failures++;
            $display("FAIL %s_data got=%h exp=0", tag, bus.o_frame_data);
        end
        checks++;
        if (bus.o_frame_rate !== 1'b0) begin
            failures++;
            $display("FAIL %s_rate got=%b exp=0", tag, bus.o_frame_rate);
        end
        checks++;
        if (bus.o_frame_len !== '0) begin
            failures++;
            $display("FAIL %s_len got=%0d exp=0", tag, bus.o_frame_len);
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        bus.i_code_rate   = 1'b0;
        bus.i_sym_valid   = 1'b0;
        bus.i_sym_data    = '0;
        bus.i_flush       = 1'b0;
        bus.i_frame_ready = 1'b0;
        m_f   = '0;
        m_cnt = 0;
        m_rate = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        check_zero_outputs("reset");
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rate2();
        logic [1:0] lo;
        logic [2:0] s;
        bus.i_frame_ready = 1'b1;
        for (int k = 0; k < SYMS_PER_FRAME; k++) begin
            lo = 2'(3 - (k % 4));
            s  = {1'(k % 2), lo};
            send_sym(s, CODE_RATE_2);
            if (k == SYMS_PER_FRAME - 2) begin
                checks++;
                if (bus.o_frame_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL r2_early_valid got=%b exp=0", bus.o_frame_valid);
                end
            end
            if (k == SYMS_PER_FRAME - 1) begin
                checks++;
                if (bus.o_frame_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL r2_valid_latency got=%b exp=1", bus.o_frame_valid);
                end
                checks++;
                if (bus.o_frame_data[255:252] !== 4'b1110) begin
                    failures++;
                    $display("FAIL r2_head got=%b exp=1110", bus.o_frame_data[255:252]);
                end
                checks++;
                if (bus.o_frame_len !== LEN_W'(128)) begin
                    failures++;
                    $display("FAIL r2_len got=%0d exp=128", bus.o_frame_len);
                end
            end
        end
        idle();
        wait_drain("rate2");
    endtask

    task automatic test_rate3();
        frame_t pat;
        pat = {128{3'b101}};
        bus.i_frame_ready = 1'b0;
        for (int k = 0; k < SYMS_PER_FRAME; k++)
            send_sym(3'b101, CODE_RATE_3);
        idle();
        checks++;
        if (bus.o_frame_data !== pat) begin
            failures++;
            $display("FAIL r3_data got=%h exp=%h", bus.o_frame_data, pat);
        end
        checks++;
        if (bus.o_frame_rate !== CODE_RATE_3) begin
            failures++;
            $display("FAIL r3_rate got=%b exp=1", bus.o_frame_rate);
        end
        bus.i_frame_ready = 1'b1;
        wait_drain("rate3");
    endtask

    task automatic test_back_to_back();
        logic [2:0] s;
        logic [2:0] held;
        bus.i_frame_ready = 1'b0;
        for (int k = 0; k < 2 * SYMS_PER_FRAME; k++) begin
            s = 3'($urandom_range(0, 7));
            send_sym(s, (k >= SYMS_PER_FRAME) ? CODE_RATE_3 : CODE_RATE_2);
        end
        checks++;
        if (bus.o_sym_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got=%b exp=0", bus.o_sym_ready);
        end
        held = 3'($urandom_range(0, 7));
        @(negedge sys_clk);
        bus.i_sym_valid = 1'b1;
        bus.i_sym_data  = held;
        bus.i_code_rate = CODE_RATE_2;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (bus.o_sym_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got=%b exp=0", bus.o_sym_ready);
        end
        bus.i_frame_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        checks++;
        if (bus.o_sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume got=%b exp=1", bus.o_sym_ready);
        end
        @(negedge sys_clk);
        bus.i_frame_ready = 1'b0;
        @(posedge sys_clk);
        model_accept(held, CODE_RATE_2);
        idle();
        bus.i_frame_ready = 1'b1;
        for (int k = 1; k < SYMS_PER_FRAME; k++) begin
            s = 3'($urandom_range(0, 7));
            send_sym(s, CODE_RATE_2);
        end
        idle();
        wait_drain("back_to_back");
    endtask

    task automatic test_rate_change();
        logic [2:0] s;
        bus.i_frame_ready = 1'b1;
        for (int k = 0; k < 2 * SYMS_PER_FRAME; k++) begin
            s = 3'($urandom_range(0, 7));
            send_sym(s, (k >= 40) ? CODE_RATE_3 : CODE_RATE_2);
        end
        idle();
        wait_drain("rate_change");
    endtask

    task automatic test_reset_mid();
        logic [2:0] s;
        bus.i_frame_ready = 1'b0;
        for (int k = 0; k < SYMS_PER_FRAME + 60; k++) begin
            s = 3'($urandom_range(0, 7));
            send_sym(s, CODE_RATE_3);
        end
        idle();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        m_f   = '0;
        m_cnt = 0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        bus.i_frame_ready = 1'b1;
        for (int k = 0; k < SYMS_PER_FRAME; k++) begin
            s = 3'($urandom_range(0, 7));
            send_sym(s, CODE_RATE_2);
        end
        idle();
        wait_drain("reset_mid");
    endtask

    task automatic test_flush();
        bus.i_frame_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send_sym(3'b001, CODE_RATE_2);
        @(negedge sys_clk);
        bus.i_sym_valid = 1'b0;
        bus.i_flush     = 1'b1;
        @(posedge sys_clk);
        #1;
`ifdef SFP_FLUSH_EN
        model_push();
        checks++;
        if (bus.o_frame_len !== LEN_W'(5)) begin
            failures++;
            $display("FAIL flush_len got=%0d exp=5", bus.o_frame_len);
        end
        checks++;
        if (bus.o_frame_data[255:246] !== 10'b0101010101) begin
            failures++;
            $display("FAIL flush_head got=%b exp=0101010101",
                     bus.o_frame_data[255:246]);
        end
        @(negedge sys_clk);
        bus.i_flush       = 1'b0;
        bus.i_frame_ready = 1'b1;
        wait_drain("flush");
        @(negedge sys_clk);
        bus.i_flush = 1'b1;
        @(negedge sys_clk);
        bus.i_flush = 1'b0;
        #1;
        checks++;
        if (bus.o_frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got=%b exp=0", bus.o_frame_valid);
        end
`else
        checks++;
        if (bus.o_frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ignored got=%b exp=0", bus.o_frame_valid);
        end
        @(negedge sys_clk);
        bus.i_flush       = 1'b0;
        bus.i_frame_ready = 1'b1;
        for (int k = 5; k < SYMS_PER_FRAME; k++)
            send_sym(3'b010, CODE_RATE_2);
        idle();
        wait_drain("flush");
`endif
    endtask

    initial begin
        test_reset();
        test_rate2();
        test_rate3();
        test_back_to_back();
        test_rate_change();
        test_reset_mid();
        test_flush();
        repeat (5) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
